axi_wr_arbiter: RTL and testbench

Shares the single AXI4 write master port between two write requesters: req0 is the picture loader pixel stream and req1 is the overlay/test-pattern writer. The block arbitrates single-beat write requests, sequences the AW/W/B channels with one transaction outstanding, and returns per-requester completion and error status. It sits between the frame-buffer writers and the m_axi interconnect port.

---
 rtl/axi_wr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_arbiter.sv
// Two-requester single-beat AXI4 write arbiter: round-robin grant, one transaction outstanding.
// Define ARB_FIXED_PRIO_EN to make req0 win every contention instead of round-robin.
module axi_wr_arbiter #(
    parameter logic [31:0] C_M_AXI_TARGET_SLAVE_BASE_ADDR = 32'h40000000,
    parameter int          ERR_CNT_W                      = 16
) (
    input  logic                 m_axi_aclk,
    input  logic                 m_axi_aresetn,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [31:0]          req0_addr,
    input  logic [31:0]          req0_data,
    output logic                 req0_done,
    output logic                 req0_err,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [31:0]          req1_addr,
    input  logic [31:0]          req1_data,
    output logic                 req1_done,
    output logic                 req1_err,
    output logic [31:0]          m_axi_awaddr,
    output logic [7:0]           m_axi_awlen,
    output logic [2:0]           m_axi_awsize,
    output logic [1:0]           m_axi_awburst,
    output logic                 m_axi_awlock,
    output logic [3:0]           m_axi_awcache,
    output logic [2:0]           m_axi_awprot,
    output logic [3:0]           m_axi_awqos,
    output logic                 m_axi_awvalid,
    input  logic                 m_axi_awready,
    output logic [31:0]          m_axi_wdata,
    output logic [3:0]           m_axi_wstrb,
    output logic                 m_axi_wlast,
    output logic                 m_axi_wvalid,
    input  logic                 m_axi_wready,
    input  logic [1:0]           m_axi_bresp,
    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t               state_q;
    logic                 owner_q;
    logic [31:0]          addr_q;
    logic [31:0]          data_q;
    logic                 awvalid_q;
    logic                 wvalid_q;
    logic                 bready_q;
    logic                 done0_q, done1_q;
    logic                 err0_q, err1_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
`ifndef ARB_FIXED_PRIO_EN
    logic                 last_grant_q;
`endif

    logic grant;
    logic accept;
    logic aw_hs;
    logic w_hs;

    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
`ifdef ARB_FIXED_PRIO_EN
            grant = 1'b0;
`else
            grant = ~last_grant_q;
`endif
        end
    end

    assign accept     = (state_q == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = (state_q == IDLE) && req0_valid && !grant;
    assign req1_ready = (state_q == IDLE) && req1_valid && grant;
    assign aw_hs      = awvalid_q && m_axi_awready;
    assign w_hs       = wvalid_q && m_axi_wready;

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            err_cnt_q    <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q       <= grant ? req1_addr : req0_addr;
                        data_q       <= grant ? req1_data : req0_data;
                        owner_q      <= grant;
`ifndef ARB_FIXED_PRIO_EN
                        last_grant_q <= grant;
`endif
                        awvalid_q    <= 1'b1;
                        wvalid_q     <= 1'b1;
                        state_q      <= XFER;
                    end
                end
                XFER: begin
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
                    // Either channel may finish first; move on once neither is still pending.
                    if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) begin
                        bready_q <= 1'b1;
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    if (m_axi_bvalid) begin
                        bready_q <= 1'b0;
                        state_q  <= IDLE;
                        if (owner_q) begin
                            done1_q <= 1'b1;
                            err1_q  <= (m_axi_bresp != 2'b00);
                        end else begin
                            done0_q <= 1'b1;
                            err0_q  <= (m_axi_bresp != 2'b00);
                        end
                        if ((m_axi_bresp != 2'b00) && (err_cnt_q != '1))
                            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_axi_awaddr  = C_M_AXI_TARGET_SLAVE_BASE_ADDR + addr_q;
    assign m_axi_awlen   = 8'h00;
    assign m_axi_awsize  = 3'h2;
    assign m_axi_awburst = 2'h1;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'h2;
    assign m_axi_awprot  = 3'h0;
    assign m_axi_awqos   = 4'h0;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = data_q;
    assign m_axi_wstrb   = 4'b1111;
    assign m_axi_wlast   = wvalid_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign req0_done     = done0_q;
    assign req0_err      = err0_q;
    assign req1_done     = done1_q;
    assign req1_err      = err1_q;
    assign busy          = (state_q != IDLE);
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Bench for axi_wr_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_axi_wr_arbiter;
    localparam logic [31:0] BASE = 32'h40000000;
    localparam int          ECW  = 4;
    localparam int          EMAX = (1 << ECW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0_valid = 0, req1_valid = 0;
    logic req0_ready, req1_ready, req0_done, req1_done, req0_err, req1_err;
    logic [31:0] req0_addr = '0, req0_data = '0, req1_addr = '0, req1_data = '0;
    logic [31:0] m_axi_awaddr, m_axi_wdata;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize, m_axi_awprot;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awlock;
    logic [3:0]  m_axi_awcache, m_axi_awqos, m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready;
    logic        m_axi_awready = 0, m_axi_wready = 0, m_axi_bvalid = 0;
    logic [1:0]  m_axi_bresp = 2'b00;
    logic        busy;
    logic [ECW-1:0] err_cnt;

    int n_chk = 0;
    int n_pass = 0;
    int model_last = 1;
    int model_err = 0;
    bit stray_b = 0;

    always #5 clk = ~clk;

    axi_wr_arbiter #(.C_M_AXI_TARGET_SLAVE_BASE_ADDR(BASE), .ERR_CNT_W(ECW)) dut (
        .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req0_done(req0_done), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .req1_done(req1_done), .req1_err(req1_err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
        .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .busy(busy), .err_cnt(err_cnt)
    );

    // Arbitration rule: lone requester wins; on contention alternate (or req0 with fixed priority).
    function automatic int pred_owner(input logic v0, input logic v1);
`ifdef ARB_FIXED_PRIO_EN
        return v0 ? 0 : 1;
`else
        if (v0 && v1) return 1 - model_last;
        return v0 ? 0 : 1;
`endif
    endfunction

    function automatic int next_err(input int cnt, input logic [1:0] br);
        if (br != 2'b00 && cnt < EMAX) return cnt + 1;
        return cnt;
    endfunction

    // Drives one request and plays the AXI slave; returns what was observed plus a protocol-ok flag.
    task automatic run_txn(input logic v0, input logic v1, input logic [31:0] a0, input logic [31:0] d0,
                           input logic [31:0] a1, input logic [31:0] d1, input int aw_dly, input int w_dly,
                           input int b_dly, input logic [1:0] br, input bit keep,
                           output int own, output logic [31:0] s_aw, output logic [31:0] s_w,
                           output logic s_last, output logic s_d0, output logic s_d1,
                           output logic s_e0, output logic s_e1, output int pulse, output bit ok);
        bit hs, aw_seen, w_seen;
        int bk, k;
        logic [31:0] aref, wref;
        ok = 1; own = -1; s_aw = '0; s_w = '0; s_last = 0;
        s_d0 = 0; s_d1 = 0; s_e0 = 0; s_e1 = 0; pulse = 0;
        req0_valid = v0; req1_valid = v1;
        req0_addr = a0; req0_data = d0; req1_addr = a1; req1_data = d1;
        #1;
        hs = 0;
        for (int i = 0; i < 50 && !hs; i++) begin
            if (req0_ready && req1_ready) ok = 0;
            if (req0_valid && req0_ready) begin own = 0; hs = 1; end
            else if (req1_valid && req1_ready) begin own = 1; hs = 1; end
            else begin @(negedge clk); #1; end
        end
        if (!hs) begin ok = 0; return; end
        @(negedge clk);
        if (!keep) begin req0_valid = 0; req1_valid = 0; end
        aw_seen = 0; w_seen = 0; bk = 0; aref = '0; wref = '0;
        for (k = 0; k < 200; k++) begin
            m_axi_awready = (k >= aw_dly);
            m_axi_wready  = (k >= w_dly);
            m_axi_bresp   = br;
            m_axi_bvalid  = m_axi_bready ? (bk >= b_dly) : (stray_b && $urandom_range(1, 0) == 1);
            #1;
            if (k == 0) begin
                if (!(m_axi_awvalid && m_axi_wvalid)) ok = 0;
                aref = m_axi_awaddr; wref = m_axi_wdata;
            end
            if (aw_seen && m_axi_awvalid) ok = 0;
            if (w_seen && m_axi_wvalid) ok = 0;
            if (m_axi_awvalid && m_axi_awaddr !== aref) ok = 0;
            if (m_axi_wvalid && m_axi_wdata !== wref) ok = 0;
            if (m_axi_bready && !(aw_seen && w_seen)) ok = 0;
            if (!busy || req0_ready || req1_ready) ok = 0;
            if (m_axi_awvalid && m_axi_awready) begin aw_seen = 1; s_aw = m_axi_awaddr; end
            if (m_axi_wvalid && m_axi_wready) begin w_seen = 1; s_w = m_axi_wdata; s_last = m_axi_wlast; end
            if (m_axi_bvalid && m_axi_bready) break;
            if (m_axi_bready) bk++;
            @(negedge clk);
        end
        if (k >= 200) begin ok = 0; return; end
        @(negedge clk);
        m_axi_bvalid = 0; m_axi_awready = 0; m_axi_wready = 0;
        #1;
        s_d0 = req0_done; s_d1 = req1_done; s_e0 = req0_err; s_e1 = req1_err;
        pulse = int'(req0_done) + int'(req1_done);
        if (busy) ok = 0;
        if (!keep) begin
            @(negedge clk); #1;
            pulse = pulse + int'(req0_done) + int'(req1_done);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy} !== 4'b0) $display("FAIL reset_ctrl got=%b exp=0000", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy}); else n_pass++;
        n_chk++; if ({req0_done, req1_done, req0_err, req1_err} !== 4'b0) $display("FAIL reset_pulses got=%b exp=0000", {req0_done, req1_done, req0_err, req1_err}); else n_pass++;
        n_chk++; if (err_cnt !== '0) $display("FAIL reset_errcnt got=%0d exp=0", err_cnt); else n_pass++;
        n_chk++; if (m_axi_awaddr !== BASE || m_axi_wdata !== 32'h0) $display("FAIL reset_latch got=%h/%h exp=%h/0", m_axi_awaddr, m_axi_wdata, BASE); else n_pass++;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        req0_valid = 1; req1_valid = 1;
        #1;
        n_chk++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL reset_first_grant got=%b exp=10", {req0_ready, req1_ready}); else n_pass++;
        req0_valid = 0; req1_valid = 0;
        @(negedge clk); #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL dropped_valid_busy got=%b exp=0", busy); else n_pass++;
    endtask

    task automatic test_single();
        int own, pulse; bit ok; logic [31:0] aw, w; logic l, d0, d1, e0, e1;
        run_txn(1, 0, 32'h10, 32'h00ABCDEF, 32'h0, 32'h0, 0, 0, 0, 2'b00, 0, own, aw, w, l, d0, d1, e0, e1, pulse, ok);
        n_chk++; if (!ok) $display("FAIL single_protocol got=0 exp=1"); else n_pass++;
        n_chk++; if (aw !== 32'h40000010) $display("FAIL single_awaddr got=%h exp=40000010", aw); else n_pass++;
        n_chk++; if (w !== 32'h00ABCDEF || l !== 1'b1) $display("FAIL single_wdata got=%h/%b exp=00abcdef/1", w, l); else n_pass++;
        n_chk++; if ({d0, e0, d1} !== 3'b100 || pulse !== 1) $display("FAIL single_done got=%b pulse=%0d exp=100 pulse=1", {d0, e0, d1}, pulse); else n_pass++;
        n_chk++; if ({m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_wstrb} !== {8'h0, 3'h2, 2'h1, 4'h2, 4'hF}) $display("FAIL single_consts got=%h", {m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_wstrb}); else n_pass++;
        model_last = 0;
    endtask

    task automatic test_round_robin();
        int own, pulse, exp_own; bit ok; logic [31:0] aw, w; logic l, d0, d1, e0, e1;
        for (int i = 0; i < 4; i++) begin
            exp_own = pred_owner(1, 1);
            run_txn(1, 1, 32'h100 + i, 32'hA0 + i, 32'h200 + i, 32'hB0 + i, 0, 0, 0, 2'b00, 1, own, aw, w, l, d0, d1, e0, e1, pulse, ok);
            n_chk++; if (!ok || own !== exp_own) $display("FAIL rr_owner_%0d got=%0d ok=%0d exp=%0d", i, own, ok, exp_own); else n_pass++;
            n_chk++; if (aw !== BASE + (exp_own == 0 ? 32'h100 + i : 32'h200 + i)) $display("FAIL rr_awaddr_%0d got=%h", i, aw); else n_pass++;
            model_last = exp_own;
        end
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_w_before_aw();
        int own, pulse; bit ok; logic [31:0] aw, w; logic l, d0, d1, e0, e1;
        run_txn(0, 1, 32'h0, 32'h0, 32'h44, 32'h12345678, 3, 0, 0, 2'b00, 0, own, aw, w, l, d0, d1, e0, e1, pulse, ok);
        n_chk++; if (!ok || own !== 1) $display("FAIL w_first_protocol got=%0d own=%0d exp=1 own=1", ok, own); else n_pass++;
        n_chk++; if (aw !== 32'h40000044 || w !== 32'h12345678) $display("FAIL w_first_payload got=%h/%h exp=40000044/12345678", aw, w); else n_pass++;
        n_chk++; if ({d1, e1, d0} !== 3'b100) $display("FAIL w_first_done got=%b exp=100", {d1, e1, d0}); else n_pass++;
        model_last = 1;
    endtask

    task automatic test_errors();
        int own, pulse; bit ok; logic [31:0] aw, w; logic l, d0, d1, e0, e1; logic [1:0] br;
        model_err = int'(err_cnt);
        run_txn(0, 1, 32'h0, 32'h0, 32'h8, 32'h55, 0, 0, 1, 2'b10, 0, own, aw, w, l, d0, d1, e0, e1, pulse, ok);
        model_err = next_err(model_err, 2'b10); model_last = 1;
        n_chk++; if (!ok || {d1, e1, d0, e0} !== 4'b1100) $display("FAIL slverr_flags got=%b exp=1100", {d1, e1, d0, e0}); else n_pass++;
        n_chk++; if (int'(err_cnt) !== model_err) $display("FAIL slverr_cnt got=%0d exp=%0d", err_cnt, model_err); else n_pass++;
        for (int i = 0; i < EMAX + 3; i++) begin
            br = ($urandom_range(1, 0) == 1) ? 2'b11 : 2'b10;
            run_txn(1, 0, 32'h20, i, 32'h0, 32'h0, 0, 0, 0, br, 0, own, aw, w, l, d0, d1, e0, e1, pulse, ok);
            model_err = next_err(model_err, br); model_last = 0;
        end
        n_chk++; if (int'(err_cnt) !== EMAX) $display("FAIL errcnt_saturate got=%0d exp=%0d", err_cnt, EMAX); else n_pass++;
        n_chk++; if (!ok || {d0, e0} !== 2'b11) $display("FAIL errcnt_last_flags got=%b exp=11", {d0, e0}); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int own, pulse; bit ok; logic [31:0] aw, w; logic l, d0, d1, e0, e1;
        @(negedge clk);
        req0_valid = 1; req0_addr = 32'h30; req0_data = 32'hDEAD;
        @(negedge clk);
        req0_valid = 0;
        #1;
        n_chk++; if (m_axi_awvalid !== 1'b1) $display("FAIL midreset_pre_awvalid got=%b exp=1", m_axi_awvalid); else n_pass++;
        rst_n = 0;
        #1;
        n_chk++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy} !== 4'b0) $display("FAIL midreset_ctrl got=%b exp=0000", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy}); else n_pass++;
        n_chk++; if (err_cnt !== '0) $display("FAIL midreset_errcnt got=%0d exp=0", err_cnt); else n_pass++;
        @(negedge clk);
        rst_n = 1; model_last = 1; model_err = 0;
        @(negedge clk);
        run_txn(1, 0, 32'h4, 32'hCAFE, 32'h0, 32'h0, 1, 2, 0, 2'b00, 0, own, aw, w, l, d0, d1, e0, e1, pulse, ok);
        n_chk++; if (!ok || aw !== 32'h40000004 || w !== 32'hCAFE || {d0, e0} !== 2'b10) $display("FAIL midreset_after got=%h/%h d0=%b ok=%0d", aw, w, d0, ok); else n_pass++;
        model_last = 0;
    endtask

    task automatic test_b_delay();
        int own, pulse; bit ok; logic [31:0] aw, w; logic l, d0, d1, e0, e1;
        run_txn(1, 0, 32'h50, 32'h77, 32'h0, 32'h0, 0, 0, 20, 2'b00, 1, own, aw, w, l, d0, d1, e0, e1, pulse, ok);
        req0_valid = 0;
        n_chk++; if (!ok) $display("FAIL bdelay_hold got=0 exp=1"); else n_pass++;
        n_chk++; if ({d0, e0, d1} !== 3'b100) $display("FAIL bdelay_done got=%b exp=100", {d0, e0, d1}); else n_pass++;
        model_last = 0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int own, pulse, exp_own; bit ok, keep; logic [31:0] aw, w, a0, a1, dd0, dd1; logic l, d0, d1, e0, e1;
        logic v0, v1; logic [1:0] br; int pat;
        model_err = int'(err_cnt);
        for (int i = 0; i < 40; i++) begin
            pat = $urandom_range(3, 1);
            v0 = pat[0]; v1 = pat[1];
            a0 = $urandom & 32'hFFFF_FFFC; a1 = $urandom & 32'hFFFF_FFFC; dd0 = $urandom; dd1 = $urandom;
            br = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
            keep = ($urandom_range(3, 0) == 0);
            stray_b = ($urandom_range(1, 0) == 1);
            exp_own = pred_owner(v0, v1);
            run_txn(v0, v1, a0, dd0, a1, dd1, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(4, 0),
                    br, keep, own, aw, w, l, d0, d1, e0, e1, pulse, ok);
            model_last = exp_own;
            model_err = next_err(model_err, br);
            n_chk++;
            if (!ok || own !== exp_own || aw !== BASE + (exp_own == 0 ? a0 : a1) || w !== (exp_own == 0 ? dd0 : dd1))
                $display("FAIL rand_txn_%0d got own=%0d aw=%h w=%h ok=%0d exp own=%0d", i, own, aw, w, ok, exp_own);
            else n_pass++;
            n_chk++;
            if ({d0, d1, e0, e1} !== {exp_own == 0, exp_own == 1, exp_own == 0 && br != 0, exp_own == 1 && br != 0})
                $display("FAIL rand_status_%0d got=%b br=%b own=%0d", i, {d0, d1, e0, e1}, br, exp_own);
            else n_pass++;
            n_chk++; if (int'(err_cnt) !== model_err) $display("FAIL rand_errcnt_%0d got=%0d exp=%0d", i, err_cnt, model_err); else n_pass++;
            if (!keep) begin
                n_chk++; if (pulse !== 1) $display("FAIL rand_pulse_%0d got=%0d exp=1", i, pulse); else n_pass++;
            end
        end
        stray_b = 0;
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_w_before_aw();
        test_errors();
        test_reset_mid();
        test_b_delay();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
